// File: rtl/led_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : led_seq_ctrl                                               |
// | Description : Pattern sequencer and shared-counter PWM for an 8-LED bank.|
// |               Produces a 4-bit duty per LED from one of four patterns    |
// |               (STATIC, CHASE with decaying trail, BREATHE, OFF). The     |
// |               pattern advances one step per prescaled tick. A single     |
// |               free-running 4-bit counter drives all eight PWM outputs.   |
// | Parameters  : TICK_DIV - clocks per pattern step (>= 2)                  |
// |               DECAY    - duty subtracted from trail LEDs per chase step  |
// | Ports       : clk   - system clock (rising edge)                         |
// |               reset - asynchronous active-high reset                     |
// |               en    - 1 = pattern runs, 0 = pattern frozen               |
// |               mode  - 00 STATIC, 01 CHASE, 10 BREATHE, 11 OFF            |
// |               sw    - peak brightness                                    |
// |               duty  - linear duty per LED, LED i = duty[4i+3:4i]         |
// |               step  - one-cycle pulse on each applied pattern step       |
// |               led   - registered PWM outputs                             |
// | Options     : LED_SEQ_GAMMA_EN - PWM compare through a gamma LUT         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module led_seq_ctrl #(
    parameter int TICK_DIV = 2_500_000,
    parameter int DECAY    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [1:0]  mode,
    input  logic [3:0]  sw,
    output logic [31:0] duty,
    output logic        step,
    output logic [7:0]  led
);

    localparam int                   c_PRESC_W   = $clog2(TICK_DIV);
    localparam logic [c_PRESC_W-1:0] c_PRESC_MAX = c_PRESC_W'(TICK_DIV - 1);
    localparam logic [4:0]           c_DECAY     = 5'(DECAY);

    localparam logic [1:0] c_ST_STATIC  = 2'b00;
    localparam logic [1:0] c_ST_CHASE   = 2'b01;
    localparam logic [1:0] c_ST_BREATHE = 2'b10;
    localparam logic [1:0] c_ST_OFF     = 2'b11;

    logic [c_PRESC_W-1:0] r_presc;
    logic [1:0]           r_state;
    logic [31:0]          r_duty;
    logic [2:0]           r_pos;
    logic                 r_dir;      // 0 = up, 1 = down (shared by CHASE and BREATHE)
    logic [3:0]           r_lvl;
    logic                 r_step;
    logic [3:0]           r_pwm_cnt;
    logic [7:0]           r_led;

    logic                 w_tick;
    logic                 w_entry;
    logic [1:0]           w_state_nxt;
    logic [31:0]          w_duty_nxt;
    logic [2:0]           w_pos_nxt;
    logic                 w_dir_nxt;
    logic [3:0]           w_lvl_nxt;
    logic [4:0]           w_lvl5;
    logic [4:0]           w_sw5;
    logic [31:0]          w_cmp;
    logic [7:0]           w_led_nxt;

    assign w_tick  = en && (r_presc == c_PRESC_MAX);
    assign w_entry = (mode != r_state);
    assign w_lvl5  = {1'b0, r_lvl};
    assign w_sw5   = {1'b0, sw};

    // Next pattern state; only committed on a tick. On a tick the state
    // always becomes mode, so the action is selected by mode directly.
    always_comb begin
        w_state_nxt = mode;
        w_duty_nxt  = r_duty;
        w_pos_nxt   = r_pos;
        w_dir_nxt   = r_dir;
        w_lvl_nxt   = r_lvl;
        case (mode)
            c_ST_STATIC: begin
                w_duty_nxt = {8{sw}};
            end
            c_ST_CHASE: begin
                if (w_entry) begin
                    w_pos_nxt  = 3'd0;
                    w_dir_nxt  = 1'b0;
                    w_duty_nxt = {28'h0, sw};
                end else begin
                    if (!r_dir) begin
                        if (r_pos == 3'd7) begin
                            w_pos_nxt = 3'd6;
                            w_dir_nxt = 1'b1;
                        end else begin
                            w_pos_nxt = r_pos + 3'd1;
                        end
                    end else begin
                        if (r_pos == 3'd0) begin
                            w_pos_nxt = 3'd1;
                            w_dir_nxt = 1'b0;
                        end else begin
                            w_pos_nxt = r_pos - 3'd1;
                        end
                    end
                    // Head gets full brightness; trail decays and saturates at 0.
                    for (int i = 0; i < 8; i++) begin
                        if (w_pos_nxt == 3'(i)) begin
                            w_duty_nxt[4*i +: 4] = sw;
                        end else if ({1'b0, r_duty[4*i +: 4]} > c_DECAY) begin
                            w_duty_nxt[4*i +: 4] = r_duty[4*i +: 4] - c_DECAY[3:0];
                        end else begin
                            w_duty_nxt[4*i +: 4] = 4'd0;
                        end
                    end
                end
            end
            c_ST_BREATHE: begin
                if (w_entry) begin
                    w_lvl_nxt = 4'd0;
                    w_dir_nxt = 1'b0;
                end else if (!r_dir) begin
                    // 5-bit compare so lvl = 15 cannot wrap.
                    if ((w_lvl5 + 5'd1) >= w_sw5) begin
                        w_lvl_nxt = sw;
                        w_dir_nxt = 1'b1;
                    end else begin
                        w_lvl_nxt = r_lvl + 4'd1;
                    end
                end else begin
                    if (r_lvl > sw) begin
                        w_lvl_nxt = sw;
                    end else if (r_lvl <= 4'd1) begin
                        w_lvl_nxt = 4'd0;
                        w_dir_nxt = 1'b0;
                    end else begin
                        w_lvl_nxt = r_lvl - 4'd1;
                    end
                end
                w_duty_nxt = {8{w_lvl_nxt}};
            end
            default: begin
                w_duty_nxt = 32'h0;
            end
        endcase
    end

`ifdef LED_SEQ_GAMMA_EN
    function automatic logic [3:0] f_gamma(input logic [3:0] d);
        logic [3:0] g;
        case (d)
            4'd0, 4'd1, 4'd2:  g = 4'd0;
            4'd3, 4'd4, 4'd5:  g = 4'd1;
            4'd6, 4'd7:        g = 4'd2;
            4'd8:              g = 4'd3;
            4'd9:              g = 4'd4;
            4'd10:             g = 4'd5;
            4'd11:             g = 4'd6;
            4'd12:             g = 4'd8;
            4'd13:             g = 4'd10;
            4'd14:             g = 4'd12;
            default:           g = 4'd15;
        endcase
        return g;
    endfunction

    always_comb begin
        w_cmp = 32'h0;
        for (int i = 0; i < 8; i++) begin
            w_cmp[4*i +: 4] = f_gamma(r_duty[4*i +: 4]);
        end
    end
`else
    assign w_cmp = r_duty;
`endif

    // Strict greater-than: duty 0 never lights, duty 15 lights 15 of 16.
    generate
        for (genvar g = 0; g < 8; g++) begin : g_led
            assign w_led_nxt[g] = (w_cmp[4*g +: 4] > r_pwm_cnt);
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc   <= '0;
            r_state   <= c_ST_OFF;
            r_duty    <= 32'h0;
            r_pos     <= 3'd0;
            r_dir     <= 1'b0;
            r_lvl     <= 4'd0;
            r_step    <= 1'b0;
            r_pwm_cnt <= 4'd0;
            r_led     <= 8'h0;
        end else begin
            if (!en || (r_presc == c_PRESC_MAX)) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
            r_step    <= w_tick;
            r_pwm_cnt <= r_pwm_cnt + 4'd1;
            r_led     <= w_led_nxt;
            if (w_tick) begin
                r_state <= w_state_nxt;
                r_duty  <= w_duty_nxt;
                r_pos   <= w_pos_nxt;
                r_dir   <= w_dir_nxt;
                r_lvl   <= w_lvl_nxt;
            end
        end
    end

    assign duty = r_duty;
    assign step = r_step;
    assign led  = r_led;

endmodule
`default_nettype wire
